// File: rtl/mmio_peripheral_if.sv
// -----------------------------------------------------------------------------
// mmio_peripheral_if
//
// Device-port bundle between the CPU MEM stage and the MMIO peripheral.
//
// Signals:
//   memAddr    - byte address from the MEM stage; 0 when no device is addressed
//   memDat     - write data from the MEM stage
//   devWrite   - write strobe (MEM-stage memWrite qualified by memAddr != 0)
//   deviceData - combinational read data for memAddr
//
// Handshake: there is no valid/ready pair on this port. devWrite acts as a
// valid that is always accepted (implicit ready = 1): each cycle it is high,
// the addressed register takes memDat at the next rising edge. Reads need no
// strobe; deviceData follows memAddr in the same cycle.
//
// Modports:
//   master - CPU side (drives address/data/strobe, samples read data)
//   slave  - peripheral side
// -----------------------------------------------------------------------------
interface mmio_peripheral_if;
    logic [31:0] memAddr;
    logic [31:0] memDat;
    logic        devWrite;
    logic [31:0] deviceData;

    modport master (
        output memAddr,
        output memDat,
        output devWrite,
        input  deviceData
    );

    modport slave (
        input  memAddr,
        input  memDat,
        input  devWrite,
        output deviceData
    );
endinterface

// File: rtl/mmio_peripheral.sv
// -----------------------------------------------------------------------------
// mmio_peripheral
//
// Memory-mapped peripheral responder on the CPU device port. Holds a
// reloadable 32-bit timer with interrupt flag, an LED register, a 4-digit
// 7-segment digit register with a multiplexed scanner, and (optionally) a
// free-running system tick counter. All registers are read combinationally
// on bus.deviceData.
//
// Register map (word decode on memAddr[31:2], bits [1:0] ignored):
//   0x40000004 TH      timer reload value, R/W
//   0x40000008 TL      timer count, R/W
//   0x4000000C TCON    [0] enable, [1] irq enable, [2] irq status
//   0x40000010 LED     low LED_WIDTH bits R/W
//   0x40000014 DIGITS  [15:0] four hex digits, digit 0 = [3:0]
//   0x40000018 SYSTICK read-only (only when MMIO_SYSTICK_EN is defined)
//   anything else: writes ignored, reads 0
//
// Build option:
//   MMIO_SYSTICK_EN - when defined, builds the SYSTICK counter and maps it at
//                     0x40000018; otherwise that address reads 0.
//
// Parameters:
//   SCAN_DIV  - clock cycles each digit is lit (2 .. 2**20)
//   LED_WIDTH - width of the LED register and the led output (1 .. 32)
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - device port (slave modport of mmio_peripheral_if)
//   irq  - registered timer interrupt (TCON[2] & TCON[1], one stage late)
//   led  - LED register
//   an   - digit anodes, active low, exactly one low
//   seg  - segments g..a, active low
// -----------------------------------------------------------------------------
module mmio_peripheral #(
    parameter int SCAN_DIV  = 50000,
    parameter int LED_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mmio_peripheral_if.slave     bus,
    output logic                 irq,
    output logic [LED_WIDTH-1:0] led,
    output logic [3:0]           an,
    output logic [6:0]           seg
);

    // Word addresses (byte address >> 2).
    localparam logic [29:0] ADDR_TH      = 30'h1000_0001;
    localparam logic [29:0] ADDR_TL      = 30'h1000_0002;
    localparam logic [29:0] ADDR_TCON    = 30'h1000_0003;
    localparam logic [29:0] ADDR_LED     = 30'h1000_0004;
    localparam logic [29:0] ADDR_DIGITS  = 30'h1000_0005;
`ifdef MMIO_SYSTICK_EN
    localparam logic [29:0] ADDR_SYSTICK = 30'h1000_0006;
`endif

    localparam int                DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);

    // ------------------------------------------------------------------
    // Address decode and write strobes
    // ------------------------------------------------------------------
    logic [29:0] word_addr;
    logic        wr_th;
    logic        wr_tl;
    logic        wr_tcon;
    logic        wr_led;
    logic        wr_digits;

    assign word_addr = bus.memAddr[31:2];
    assign wr_th     = bus.devWrite && (word_addr == ADDR_TH);
    assign wr_tl     = bus.devWrite && (word_addr == ADDR_TL);
    assign wr_tcon   = bus.devWrite && (word_addr == ADDR_TCON);
    assign wr_led    = bus.devWrite && (word_addr == ADDR_LED);
    assign wr_digits = bus.devWrite && (word_addr == ADDR_DIGITS);

    // ------------------------------------------------------------------
    // Timer
    // ------------------------------------------------------------------
    logic [31:0] th_q;
    logic [31:0] tl_q;
    logic [2:0]  tcon_q;
    logic        tmr_en;
    logic        tmr_ovf;

    assign tmr_en  = tcon_q[0];
    assign tmr_ovf = tmr_en && (tl_q == 32'hFFFF_FFFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
            irq    <= 1'b0;
        end else begin
            // The reload below reads th_q, so a TH write in the same
            // cycle only affects the next reload.
            if (wr_th) begin
                th_q <= bus.memDat;
            end

            // Software write to TL wins over increment and reload.
            if (wr_tl) begin
                tl_q <= bus.memDat;
            end else if (tmr_ovf) begin
                tl_q <= th_q;
            end else if (tmr_en) begin
                tl_q <= tl_q + 32'd1;
            end

            // Status is OR-ed with the overflow so a software clear that
            // collides with an overflow never drops the event.
            if (wr_tcon) begin
                tcon_q[1:0] <= bus.memDat[1:0];
                tcon_q[2]   <= bus.memDat[2] | tmr_ovf;
            end else if (tmr_ovf) begin
                tcon_q[2] <= 1'b1;
            end

            irq <= tcon_q[2] & tcon_q[1];
        end
    end

    // ------------------------------------------------------------------
    // LED and digit registers
    // ------------------------------------------------------------------
    logic [LED_WIDTH-1:0] led_q;
    logic [15:0]          digits_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q    <= '0;
            digits_q <= '0;
        end else begin
            if (wr_led) begin
                led_q <= bus.memDat[LED_WIDTH-1:0];
            end
            if (wr_digits) begin
                digits_q <= bus.memDat[15:0];
            end
        end
    end

    assign led = led_q;

    // ------------------------------------------------------------------
    // System tick counter (optional)
    // ------------------------------------------------------------------
`ifdef MMIO_SYSTICK_EN
    logic [31:0] systick_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            systick_q <= '0;
        end else begin
            systick_q <= systick_q + 32'd1;   // wraps naturally at 2**32
        end
    end
`endif

    // ------------------------------------------------------------------
    // 7-segment scanner
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic [1:0]       idx_q;
    logic [3:0]       cur_nibble;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
            idx_q <= idx_q + 2'd1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Glyphs in g..a order, active low; b and d are lowercase.
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;   // 4'hF
        endcase
        return g;
    endfunction

    // an and seg decode straight from registers, so the divider wrap
    // cannot produce an extra or missing anode cycle.
    always_comb begin
        case (idx_q)
            2'd0:    cur_nibble = digits_q[3:0];
            2'd1:    cur_nibble = digits_q[7:4];
            2'd2:    cur_nibble = digits_q[11:8];
            default: cur_nibble = digits_q[15:12];
        endcase
    end

    always_comb begin
        an        = 4'b1111;
        an[idx_q] = 1'b0;
    end

    assign seg = hex_glyph(cur_nibble);

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] rd_data;

    always_comb begin
        rd_data = '0;
        case (word_addr)
            ADDR_TH:      rd_data = th_q;
            ADDR_TL:      rd_data = tl_q;
            ADDR_TCON:    rd_data = {29'd0, tcon_q};
            ADDR_LED:     rd_data[LED_WIDTH-1:0] = led_q;
            ADDR_DIGITS:  rd_data = {16'd0, digits_q};
`ifdef MMIO_SYSTICK_EN
            ADDR_SYSTICK: rd_data = systick_q;
`endif
            default:      rd_data = '0;
        endcase
    end

    assign bus.deviceData = rd_data;

endmodule

// File: tb/tb_mmio_peripheral.sv
// -----------------------------------------------------------------------------
// tb_mmio_peripheral
//
// Directed and randomized checks of mmio_peripheral (SCAN_DIV=4, LED_WIDTH=8)
// against a cycle-level reference model of the register map, timer rules and
// scanner kept in this file.
// -----------------------------------------------------------------------------
module tb_mmio_peripheral;

    localparam int SCAN_DIV  = 4;
    localparam int LED_WIDTH = 8;

    localparam logic [31:0] A_NONE    = 32'h0000_0000;
    localparam logic [31:0] A_BASE    = 32'h4000_0000;
    localparam logic [31:0] A_TH      = 32'h4000_0004;
    localparam logic [31:0] A_TL      = 32'h4000_0008;
    localparam logic [31:0] A_TCON    = 32'h4000_000C;
    localparam logic [31:0] A_LED     = 32'h4000_0010;
    localparam logic [31:0] A_DIGITS  = 32'h4000_0014;
    localparam logic [31:0] A_SYSTICK = 32'h4000_0018;
    localparam logic [31:0] A_HOLE    = 32'h4000_001C;

    // ---------------- clock / reset ----------------
    logic                 clk = 1'b0;
    logic                 rst;
    logic                 irq;
    logic [LED_WIDTH-1:0] led;
    logic [3:0]           an;
    logic [6:0]           seg;

    always #10 clk = ~clk;

    mmio_peripheral_if bus ();

    mmio_peripheral #(
        .SCAN_DIV  (SCAN_DIV),
        .LED_WIDTH (LED_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .irq (irq),
        .led (led),
        .an  (an),
        .seg (seg)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_th;
    logic [31:0] m_tl;
    logic [2:0]  m_tcon;
    logic        m_irq;
    logic [7:0]  m_led;
    logic [15:0] m_digits;
    logic [31:0] m_systick;
    int          m_scan;        // clock edges since the last reset edge
    logic [6:0]  glyph_tab [16];

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:2] == A_TH[31:2])      return m_th;
        if (a[31:2] == A_TL[31:2])      return m_tl;
        if (a[31:2] == A_TCON[31:2])    return {29'd0, m_tcon};
        if (a[31:2] == A_LED[31:2])     return {24'd0, m_led};
        if (a[31:2] == A_DIGITS[31:2])  return {16'd0, m_digits};
`ifdef MMIO_SYSTICK_EN
        if (a[31:2] == A_SYSTICK[31:2]) return m_systick;
`endif
        return 32'd0;
    endfunction

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reads are issued after the falling edge, well clear of the next rise.
    task automatic check_read(input string tag, input logic [31:0] a);
        logic [31:0] e;
        exp_q.push_back(m_read(a));
        bus.memAddr = a;
        #1;
        e = exp_q.pop_front();
        check(tag, bus.deviceData, e);
        bus.memAddr = A_NONE;
    endtask

    task automatic check_outputs(input string tag);
        int         idx;
        logic [3:0] nib;
        idx = (m_scan / SCAN_DIV) % 4;
        nib = m_digits[idx*4 +: 4];
        check({tag, "_irq"}, {31'd0, irq}, {31'd0, m_irq});
        check({tag, "_led"}, {24'd0, led}, {24'd0, m_led});
        check({tag, "_an"},  {28'd0, an},  {28'd0, ~(4'b0001 << idx)});
        check({tag, "_seg"}, {25'd0, seg}, {25'd0, glyph_tab[nib]});
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] addrs [8];
        addrs = '{A_BASE, A_TH, A_TL, A_TCON, A_LED, A_DIGITS, A_SYSTICK, A_HOLE};
        for (int i = 0; i < 8; i++) begin
            check_read($sformatf("%s_rd%h", tag, addrs[i]), addrs[i]);
        end
    endtask

    // ---------------- driver ----------------
    // Advance one clock: model the edge from the inputs currently driven,
    // then return at the following falling edge.
    task automatic tick();
        logic [31:0] a, d, n_th, n_tl, n_systick;
        logic        w, ovf, n_irq;
        logic [2:0]  n_tcon;
        logic [7:0]  n_led;
        logic [15:0] n_digits;
        int          n_scan;
        a = bus.memAddr;
        d = bus.memDat;
        w = bus.devWrite;
        if (rst) begin
            n_th = 0; n_tl = 0; n_tcon = 0; n_irq = 0;
            n_led = 0; n_digits = 0; n_systick = 0; n_scan = 0;
        end else begin
            ovf       = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
            n_th      = m_th;
            n_tl      = m_tl;
            if (m_tcon[0]) n_tl = ovf ? m_th : m_tl + 32'd1;
            n_tcon    = m_tcon;
            if (ovf) n_tcon[2] = 1'b1;
            n_irq     = m_tcon[2] & m_tcon[1];
            n_led     = m_led;
            n_digits  = m_digits;
            n_systick = m_systick + 32'd1;
            n_scan    = m_scan + 1;
            if (w) begin
                if (a[31:2] == A_TH[31:2])     n_th = d;
                if (a[31:2] == A_TL[31:2])     n_tl = d;
                if (a[31:2] == A_TCON[31:2])   n_tcon = {d[2] | ovf, d[1:0]};
                if (a[31:2] == A_LED[31:2])    n_led = d[7:0];
                if (a[31:2] == A_DIGITS[31:2]) n_digits = d[15:0];
            end
        end
        @(posedge clk);
        m_th = n_th; m_tl = n_tl; m_tcon = n_tcon; m_irq = n_irq;
        m_led = n_led; m_digits = n_digits; m_systick = n_systick; m_scan = n_scan;
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.memAddr  = a;
        bus.memDat   = d;
        bus.devWrite = 1'b1;
        tick();
        bus.devWrite = 1'b0;
        bus.memAddr  = A_NONE;
        bus.memDat   = 32'd0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        glyph_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        m_th = 0; m_tl = 0; m_tcon = 0; m_irq = 0;
        m_led = 0; m_digits = 0; m_systick = 0; m_scan = 0;
        rst          = 1'b1;
        bus.memAddr  = A_NONE;
        bus.memDat   = 32'd0;
        bus.devWrite = 1'b0;
        @(negedge clk);
        tick();
        tick();

        // Reset state
        check("rst_an",  {28'd0, an},  32'h0000_000E);
        check("rst_seg", {25'd0, seg}, 32'h0000_0040);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_led", {24'd0, led}, 32'd0);
        check("rst_dd0", bus.deviceData, 32'd0);
        rst = 1'b0;
        check_regs("rst");

        // Timer overflow and reload
        wr(A_TH, 32'hFFFF_FFF0);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 32'd3);
        check_read("tl_at_enable", A_TL);
        tick();
        check_read("tl_first_inc", A_TL);
        check("tl_ffffffff", m_read(A_TL), 32'hFFFF_FFFF);
        bus.memAddr = A_TL; #1;
        check("tl_ffffffff_dut", bus.deviceData, 32'hFFFF_FFFF);
        bus.memAddr = A_NONE;
        tick();
        bus.memAddr = A_TL; #1;
        check("tl_reloaded", bus.deviceData, 32'hFFFF_FFF0);
        bus.memAddr = A_TCON; #1;
        check("tcon_is_7", bus.deviceData, 32'd7);
        bus.memAddr = A_NONE;
        check("irq_not_yet", {31'd0, irq}, 32'd0);
        tick();
        check("irq_rises", {31'd0, irq}, 32'd1);
        check_outputs("ovf1");

        // TCON write colliding with an overflow keeps the status bit
        wr(A_TL, 32'hFFFF_FFFF);
        wr(A_TCON, 32'd3);
        bus.memAddr = A_TCON; #1;
        check("tcon_collide", bus.deviceData, 32'd7);
        bus.memAddr = A_NONE;
        check("irq_collide", {31'd0, irq}, 32'd1);
        tick();
        check("irq_still_high", {31'd0, irq}, 32'd1);
        wr(A_TCON, 32'd3);
        check_read("tcon_cleared", A_TCON);
        tick();
        check("irq_falls", {31'd0, irq}, 32'd0);

        // TH write in an overflow cycle: reload uses the old TH
        wr(A_TL, 32'hFFFF_FFFF);
        wr(A_TH, 32'h0000_0055);
        bus.memAddr = A_TL; #1;
        check("tl_old_th", bus.deviceData, 32'hFFFF_FFF0);
        bus.memAddr = A_NONE;
        check_regs("th_ovf");
        wr(A_TCON, 32'd0);

        // LED register and unmapped writes
        wr(A_LED, 32'h0000_01A5);
        check("led_out", {24'd0, led}, 32'h0000_00A5);
        bus.memAddr = A_LED; #1;
        check("led_rd", bus.deviceData, 32'h0000_00A5);
        bus.memAddr = A_LED | 32'd1; #1;
        check("led_rd_byteoff", bus.deviceData, 32'h0000_00A5);
        bus.memAddr = A_NONE;
        wr(A_BASE, $urandom());
        wr(A_HOLE, $urandom());
        wr(A_SYSTICK, $urandom());
        check_regs("unmapped");

        // Scanner
        wr(A_DIGITS, 32'h0000_3A0F);
        for (int i = 0; i < 4 * SCAN_DIV + 3; i++) begin
            check_outputs($sformatf("scan%0d", i));
            tick();
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int unsigned k;
            logic [31:0] a, d;
            k = $urandom_range(0, 7);
            a = A_BASE + 32'(k * 4) + 32'($urandom_range(0, 3));
            d = $urandom();
            if (k == 2) begin
                case ($urandom_range(0, 2))
                    0:       d = 32'hFFFF_FFFF;
                    1:       d = 32'hFFFF_FFFF - 32'($urandom_range(1, 6));
                    default: d = $urandom();
                endcase
            end
            if (k == 1 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF8;
            rst = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 2) != 0) begin
                wr(a, d);
            end else begin
                tick();
            end
            rst = 1'b0;
            check_outputs($sformatf("rnd%0d", i));
            check_read($sformatf("rnd%0d_rd", i), A_BASE + 32'($urandom_range(0, 7) * 4));
        end

        // Reset mid-count overrides a concurrent write
        wr(A_DIGITS, 32'h0000_1234);
        wr(A_TL, 32'h0000_1234);
        wr(A_TCON, 32'd3);
        tick();
        tick();
        rst          = 1'b1;
        bus.memAddr  = A_LED;
        bus.memDat   = 32'h0000_00FF;
        bus.devWrite = 1'b1;
        tick();
        bus.devWrite = 1'b0;
        bus.memAddr  = A_NONE;
        rst          = 1'b0;
        check("midrst_an",  {28'd0, an},  32'h0000_000E);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        check("midrst_led", {24'd0, led}, 32'd0);
        bus.memAddr = A_TL; #1;
        check("midrst_tl", bus.deviceData, 32'd0);
        bus.memAddr = A_TCON; #1;
        check("midrst_tcon", bus.deviceData, 32'd0);
        bus.memAddr = A_NONE;
        check_regs("midrst");
        for (int i = 0; i < 10; i++) tick();
        bus.memAddr = A_SYSTICK; #1;
`ifdef MMIO_SYSTICK_EN
        check("systick_10", bus.deviceData, 32'd10);
`else
        check("systick_off", bus.deviceData, 32'd0);
`endif
        bus.memAddr = A_NONE;
        check_regs("final");
        check_outputs("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmio_peripheral.md
# mmio_peripheral

Memory-mapped peripheral responder on the CPU's device port: decodes word writes above 0x40000000, holds timer, LED and 7-segment registers, and returns register contents on `deviceData`. Contains a reloadable 32-bit timer with interrupt flag, a free-running system tick counter and a multiplexed 4-digit 7-segment scanner. Sits beside the CPU top and is clocked by the same `clk`.

## Interface
- `SCAN_DIV`, 50000: clock cycles each 7-seg digit is lit; legal range 2..2^20.
- `LED_WIDTH`, 8: number of LED register bits driven to `led`.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `memAddr`  in  32  byte address from the MEM stage; 0 when the CPU is not addressing a device.
- `memDat`  in  32  write data from the MEM stage.
- `devWrite`  in  1  write strobe: MEM-stage memWrite qualified by `memAddr != 0`.
- `deviceData`  out  32  read data for `memAddr`, combinational.
- `irq`  out  1  timer interrupt, registered; equals TCON[2] & TCON[1].
- `led`  out  LED_WIDTH  LED register.
- `an`  out  4  digit anodes, active low, one-hot-zero.
- `seg`  out  7  segments g..a, active low.

## Operation
- Word-aligned decode on memAddr[31:2]; bits [1:0] ignored. Register map:
  - 0x40000004 TH: timer reload value, R/W.
  - 0x40000008 TL: timer count, R/W.
  - 0x4000000C TCON: [0] enable, [1] irq enable, [2] irq status; bits [31:3] read 0.
  - 0x40000010 LED: low LED_WIDTH bits R/W, upper bits read 0.
  - 0x40000014 DIGITS: [15:0] four hex digits, digit 0 = [3:0]; upper bits read 0.
  - 0x40000018 SYSTICK: read-only.
- Unmapped addresses, including 0x40000000: writes ignored, reads return 0.
- Write: when `devWrite`=1, the addressed register takes `memDat` at the next edge.
- Timer, when TCON[0]=1, per cycle:
  - TL != 0xFFFFFFFF: TL <= TL+1.
  - TL == 0xFFFFFFFF: TL <= TH; TCON[2] <= 1.
  - TCON[0]=0: TL holds.
- TCON[2] is cleared only by a software write of 0 to bit 2. Writing 1 to bit 2 sets it.
- Simultaneous events:
  - Software write to TL in an increment/reload cycle: write wins.
  - Software write to TCON in an overflow cycle: bits [1:0] take the written value; bit 2 ends at 1, so an overflow is never lost.
  - Write to TH in an overflow cycle: reload uses the old TH.
- Scanner:
  - Divider counts 0..SCAN_DIV-1; at terminal count, the digit index advances 0->1->2->3->0.
  - `an` is low only at the current index.
  - `seg` shows the hex glyph of DIGITS nibble[index], covering 0-9 and A-F (b and d lowercase).

## Timing
- Reset values:
  - TH, TL, TCON, LED, DIGITS, SYSTICK: 0.
  - `irq`: 0.
  - `led`: 0.
  - Divider and digit index: 0.
  - `an`: 4'b1110.
  - `seg`: glyph "0" = 7'b1000000.
  - `deviceData`: 0 while memAddr is 0.
- Reads have zero latency: `deviceData` reflects register state in the same cycle. A register written at edge N reads the new value from cycle N+1.
- `irq` rises the cycle after the edge on which TCON[2] and TCON[1] are both 1 (one register stage).
- With TL=0xFFFFFFFF and enable=1 at edge N: TL=TH after N, TCON[2]=1 after N, `irq` high after N+1.
- Reset asserted mid-count or mid-scan returns every register to its reset value on that edge. Reset overrides a concurrent write.
- SYSTICK wraps from 0xFFFFFFFF to 0. The divider wraps without a glitch cycle on `an`.

## Configuration
- `MMIO_SYSTICK_EN` defined:
  - SYSTICK increments every cycle after reset.
  - Reads at 0x40000018 return it.
- Not defined:
  - No SYSTICK counter is built.
  - 0x40000018 behaves as unmapped and reads 0.

## Test plan
- Write TH=0xFFFFFFF0 and TL=0xFFFFFFFE, then TCON=3 -> TL reads 0xFFFFFFFF one cycle after enable, then 0xFFFFFFF0. TCON reads 7. `irq` high one cycle after status sets.
- With `irq` high, write TCON=3 in the same cycle as a second overflow -> TCON[2] stays 1 and `irq` stays high. Write TCON=3 in a non-overflow cycle -> `irq` low next cycle.
- Write LED=0x1A5 with LED_WIDTH=8 -> `led`=0xA5 and read returns 0xA5. Write to 0x40000000 or 0x4000001C -> no register changes, reads return 0.
- SCAN_DIV=4, DIGITS=0x3A0F:
  - `an` cycles 1110, 1101, 1011, 0111 every 4 cycles.
  - `seg` cycles 0001110, 1000000, 0001000, 0110000.
- Assert `rst` mid-count with TL=0x1234 and enabled -> next cycle all registers 0, `an`=1110, `irq`=0. With `MMIO_SYSTICK_EN`, SYSTICK reads 10 ten cycles after reset release. Without it, SYSTICK reads 0.
